bus_debug_master: RTL and testbench

Byte-stream-driven initiator for the on-chip simple memory bus (valid/ready, OR-combined read data). It parses framed read/write commands from a byte source such as the fiber UART receive path, issues one 32-bit bus transaction per command, and returns the result as a byte stream. It gives the host direct register access to the peripheral map (GPIO, QCW ramp/driver/OCD, boost) without firmware involvement. It sits in the 80 MHz domain, as an alternate initiator ahead of the bus arbitration or clock-crossing input.

---
 rtl/bus_debug_master.sv | 211 +++++++++++++++++++++
 tb/tb_bus_debug_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_debug_master.sv
// bus_debug_master: byte-framed command parser that issues one 32-bit access
// on the simple memory bus per command and streams the result back.
// Frame: opcode (0x57 write / 0x52 read), 4 address bytes MSB first,
// then for writes 4 data bytes MSB first.
module bus_debug_master #(
  parameter int BUS_TIMEOUT  = 1024,
  parameter int BYTE_TIMEOUT = 800000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy,
  output logic        rx_dropped
);

  localparam int BUS_CW  = (BUS_TIMEOUT  > 2) ? $clog2(BUS_TIMEOUT)  : 1;
  localparam int BYTE_CW = (BYTE_TIMEOUT > 2) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam logic [BUS_CW-1:0]  BUS_LAST  = BUS_CW'(BUS_TIMEOUT - 1);
  localparam logic [BYTE_CW-1:0] BYTE_LAST = BYTE_CW'(BYTE_TIMEOUT - 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic                 is_write_r;
  logic [1:0]           byte_idx_r;
  logic [BYTE_CW-1:0]   byte_cnt_r;
  logic [BUS_CW-1:0]    bus_cnt_r;
  logic [31:0]          rdata_r;     // remaining read bytes, next one in [31:24]
  logic [1:0]           tx_rem_r;    // bytes still to send after the current one

  logic opcode_ok_s;
  logic last_byte_s;
  logic byte_to_s;
  logic bus_done_s;
  logic bus_nak_s;
  logic tx_hs_s;
  logic tx_last_s;

  assign opcode_ok_s = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign last_byte_s = (byte_idx_r == 2'd3);
  assign byte_to_s   = !rx_valid && (byte_cnt_r == BYTE_LAST);
  assign bus_done_s  = mem_valid_o && mem_ready_i;
  // ready on the final count wins over the timeout
  assign bus_nak_s   = mem_valid_o && !mem_ready_i && (bus_cnt_r == BUS_LAST);
  assign tx_hs_s     = tx_valid && tx_ready;
  assign tx_last_s   = (tx_rem_r == 2'd0);

  // Next-state decode for the frame / bus / response sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && opcode_ok_s) state_s = ST_ADDR;
        else                         state_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (rx_valid) begin
          if (last_byte_s) state_s = is_write_r ? ST_DATA : ST_BUS;
          else             state_s = ST_ADDR;
        end else if (byte_to_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          if (last_byte_s) state_s = ST_BUS;
          else             state_s = ST_DATA;
        end else if (byte_to_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_BUS: begin
        if (bus_done_s || bus_nak_s) state_s = ST_RESP;
        else                         state_s = ST_BUS;
      end
      ST_RESP: begin
        if (tx_hs_s && tx_last_s) state_s = ST_IDLE;
        else                      state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, frame capture, bus request and response byte sequencing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      is_write_r  <= 1'b0;
      byte_idx_r  <= 2'd0;
      byte_cnt_r  <= '0;
      bus_cnt_r   <= '0;
      rdata_r     <= 32'h0;
      tx_rem_r    <= 2'd0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_wstrb_o <= 4'h0;
      busy        <= 1'b0;
      rx_dropped  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != ST_IDLE);
      if (rx_valid && ((state_r == ST_BUS) || (state_r == ST_RESP))) begin
        rx_dropped <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (rx_valid && opcode_ok_s) begin
            is_write_r <= (rx_data == OP_WRITE);
            byte_idx_r <= 2'd0;
            byte_cnt_r <= '0;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            mem_addr_o <= {mem_addr_o[23:0], rx_data};
            byte_idx_r <= byte_idx_r + 2'd1;
            byte_cnt_r <= '0;
            if (last_byte_s && !is_write_r) begin
              mem_valid_o <= 1'b1;
              mem_wstrb_o <= 4'h0;
              bus_cnt_r   <= '0;
            end
          end else begin
            byte_cnt_r <= byte_cnt_r + BYTE_CW'(1'b1);
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            mem_wdata_o <= {mem_wdata_o[23:0], rx_data};
            byte_idx_r  <= byte_idx_r + 2'd1;
            byte_cnt_r  <= '0;
            if (last_byte_s) begin
              mem_valid_o <= 1'b1;
              mem_wstrb_o <= 4'hF;
              bus_cnt_r   <= '0;
            end
          end else begin
            byte_cnt_r <= byte_cnt_r + BYTE_CW'(1'b1);
          end
        end
        ST_BUS: begin
          if (bus_done_s) begin
            mem_valid_o <= 1'b0;
            tx_valid    <= 1'b1;
            rdata_r     <= {mem_rdata_i[23:0], 8'h00};
            if (is_write_r) begin
              tx_data  <= RSP_ACK;
              tx_rem_r <= 2'd0;
            end else begin
              tx_data  <= mem_rdata_i[31:24];
              tx_rem_r <= 2'd3;
            end
          end else if (bus_nak_s) begin
            mem_valid_o <= 1'b0;
            tx_valid    <= 1'b1;
            tx_data     <= RSP_NAK;
            tx_rem_r    <= 2'd0;
          end else begin
            bus_cnt_r <= bus_cnt_r + BUS_CW'(1'b1);
          end
        end
        ST_RESP: begin
          if (tx_hs_s) begin
            if (tx_last_s) begin
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
            end else begin
              tx_data  <= rdata_r[31:24];
              rdata_r  <= {rdata_r[23:0], 8'h00};
              tx_rem_r <= tx_rem_r - 2'd1;
            end
          end
        end
        default: begin
          mem_valid_o <= 1'b0;
          tx_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_debug_master.sv
// Directed testbench for bus_debug_master with a small bus responder model.
module tb_bus_debug_master;

  logic        clk;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        busy;
  logic        rx_dropped;

  int passed = 0;
  int total  = 0;

  // responder configuration (written by the stimulus) and observations
  int          resp_delay = 0;      // ready in this valid cycle (1-based); 0 = never
  logic [31:0] resp_rdata = 32'h0;
  int          rcnt        = 0;
  int          txn_total   = 0;
  int          valid_total = 0;
  int          stab_err    = 0;
  logic [31:0] a0 = 32'h0;
  logic [31:0] w0 = 32'h0;
  logic [3:0]  s0 = 4'h0;

  bus_debug_master #(.BUS_TIMEOUT(16), .BYTE_TIMEOUT(100)) dut (
    .clk(clk), .resetn(resetn),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .busy(busy), .rx_dropped(rx_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus responder: counts valid cycles, records the request, checks stability.
  always @(negedge clk) begin
    if (mem_valid_o) begin
      if (rcnt == 0) begin
        txn_total = txn_total + 1;
        a0 = mem_addr_o;
        w0 = mem_wdata_o;
        s0 = mem_wstrb_o;
      end else if (mem_addr_o !== a0 || mem_wdata_o !== w0 || mem_wstrb_o !== s0) begin
        stab_err = stab_err + 1;
      end
      valid_total = valid_total + 1;
      mem_ready_i = (resp_delay != 0) && (rcnt == resp_delay - 1);
      mem_rdata_i = mem_ready_i ? resp_rdata : 32'h0;
      rcnt = rcnt + 1;
    end else begin
      mem_ready_i = 1'b0;
      mem_rdata_i = 32'h0;
      rcnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_read(input logic [31:0] addr);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
  endtask

  task automatic send_write(input logic [31:0] addr, input logic [31:0] data);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
  endtask

  // Collect n response bytes (MSB of exp_w first); rnd toggles tx_ready randomly,
  // otherwise tx_ready stays high and bytes must arrive back-to-back.
  task automatic get_resp(input logic [31:0] exp_w, input int n, input bit rnd, input string tag);
    int idx = 0;
    int cyc = 0;
    int gaps = 0;
    bit started = 1'b0;
    logic [7:0] e;
    while (idx < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid) begin
        started = 1'b1;
        e = exp_w[8*(n-1-idx) +: 8];
        check({tag, "_byte"}, {24'h0, tx_data}, {24'h0, e});
        if (tx_ready) idx++;
      end else if (started && !rnd) begin
        gaps++;
      end
    end
    check({tag, "_count"}, idx, n);
    check({tag, "_gaps"}, gaps, 0);
    @(negedge clk);
    tx_ready = 1'b0;
    check({tag, "_txv_low"}, {31'h0, tx_valid}, 32'h0);
    check({tag, "_busy_low"}, {31'h0, busy}, 32'h0);
  endtask

  int t0;
  int v0;

  initial begin
    resetn   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_mem_valid", {31'h0, mem_valid_o}, 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_wstrb", {28'h0, mem_wstrb_o}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_dropped", {31'h0, rx_dropped}, 32'h0);
    resetn = 1'b1;

    // write, ready in the third valid cycle
    resp_delay = 3;
    t0 = txn_total; v0 = valid_total;
    send_write(32'h1200_0004, 32'hDEAD_BEEF);
    check("wr_valid_next", {31'h0, mem_valid_o}, 32'h1);
    check("wr_busy", {31'h0, busy}, 32'h1);
    get_resp(32'h06, 1, 1'b0, "wr_resp");
    check("wr_txn", txn_total - t0, 1);
    check("wr_addr", a0, 32'h1200_0004);
    check("wr_wdata", w0, 32'hDEAD_BEEF);
    check("wr_wstrb", {28'h0, s0}, 32'hF);
    check("wr_valid_cycles", valid_total - v0, 3);

    // read, ready in the first valid cycle, back-to-back response
    resp_delay = 1;
    resp_rdata = 32'hA5C3_0F01;
    t0 = txn_total; v0 = valid_total;
    send_read(32'h1000_0000);
    get_resp(32'hA5C3_0F01, 4, 1'b0, "rd_resp");
    check("rd_txn", txn_total - t0, 1);
    check("rd_addr", a0, 32'h1000_0000);
    check("rd_wstrb", {28'h0, s0}, 32'h0);
    check("rd_valid_cycles", valid_total - v0, 1);

    // bus timeout: never ready
    resp_delay = 0;
    v0 = valid_total;
    send_read(32'h0000_0100);
    get_resp(32'h15, 1, 1'b0, "to_resp");
    check("to_valid_cycles", valid_total - v0, 16);

    // ready on the final count wins
    resp_delay = 16;
    resp_rdata = 32'h0BAD_F00D;
    v0 = valid_total;
    send_read(32'h0000_0104);
    get_resp(32'h0BAD_F00D, 4, 1'b0, "to16_resp");
    check("to16_valid_cycles", valid_total - v0, 16);

    // resync on junk bytes, then byte timeout on a partial frame
    t0 = txn_total;
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk_busy", {31'h0, busy}, 32'h0);
    send_byte(8'h52);
    check("partial_busy", {31'h0, busy}, 32'h1);
    repeat (90) @(negedge clk);
    check("bto_busy_before", {31'h0, busy}, 32'h1);
    repeat (12) @(negedge clk);
    check("bto_busy_after", {31'h0, busy}, 32'h0);
    check("bto_no_txn", txn_total - t0, 0);
    resp_delay = 1;
    resp_rdata = 32'hCAFE_F00D;
    send_read(32'h4000_0008);
    get_resp(32'hCAFE_F00D, 4, 1'b0, "resync_resp");
    check("resync_addr", a0, 32'h4000_0008);

    // backpressure plus a dropped rx byte during RESP
    resp_delay = 2;
    resp_rdata = 32'h1234_5678;
    tx_ready = 1'b0;
    send_read(32'h2000_000C);
    repeat (2) @(negedge clk);
    check("bp_txv", {31'h0, tx_valid}, 32'h1);
    check("bp_first", {24'h0, tx_data}, 32'h12);
    rx_data  = 8'h57;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("drop_flag", {31'h0, rx_dropped}, 32'h1);
    check("drop_hold", {24'h0, tx_data}, 32'h12);
    get_resp(32'h1234_5678, 4, 1'b1, "bp_resp");
    check("drop_sticky", {31'h0, rx_dropped}, 32'h1);

    // reset in the middle of a bus cycle
    resp_delay = 0;
    send_read(32'h0000_0020);
    repeat (4) @(negedge clk);
    check("mid_valid", {31'h0, mem_valid_o}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("arst_valid", {31'h0, mem_valid_o}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_addr", mem_addr_o, 32'h0);
    check("arst_txv", {31'h0, tx_valid}, 32'h0);
    check("arst_dropped", {31'h0, rx_dropped}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    resp_delay = 1;
    t0 = txn_total;
    send_write(32'h0000_0020, 32'h0000_0055);
    get_resp(32'h06, 1, 1'b0, "post_rst_resp");
    check("post_rst_txn", txn_total - t0, 1);
    check("post_rst_addr", a0, 32'h0000_0020);
    check("post_rst_wdata", w0, 32'h0000_0055);
    check("post_rst_stab", stab_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
